// File: rtl/leaf_result_collector.sv
// Leaf result collector: decodes final-stage leaf nodes of both lanes,
// buffers them per lane and merges them round-robin onto one stream.
// Optional statistics counters are built when COLLECT_STATS_EN is defined.
// Ports:
//   clk, RSTn                      clock, async active-low reset
//   packet_in1/2, data_valid_in1/2 lane header and valid (no stall)
//   node_in1/2, matched_in1/2      final node word, leaf flag
//   res_valid/res_ready            result stream handshake
//   res_lane, res_seq, res_hit     source lane, per-lane tag, leaf hit
//   res_level, res_leaf_addr       node level, leaf base address
//   res_num_rules, res_packet      decoded rule count, header
//   drop_cnt1/2                    saturating overflow drop counts
//   hit_cnt, miss_cnt              transferred hit/miss statistics
module leaf_result_collector #(
    parameter int PACKET_WIDTH = 104,
    parameter int NODE_WIDTH   = 40,
    parameter int LEAF_ADDR    = 12,
    parameter int FIFO_AW      = 3,
    parameter int SEQ_W        = 16
) (
    input  logic                    clk,
    input  logic                    RSTn,
    input  logic [PACKET_WIDTH-1:0] packet_in1,
    input  logic [PACKET_WIDTH-1:0] packet_in2,
    input  logic                    data_valid_in1,
    input  logic                    data_valid_in2,
    input  logic [NODE_WIDTH-1:0]   node_in1,
    input  logic [NODE_WIDTH-1:0]   node_in2,
    input  logic                    matched_in1,
    input  logic                    matched_in2,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_lane,
    output logic [SEQ_W-1:0]        res_seq,
    output logic                    res_hit,
    output logic [2:0]              res_level,
    output logic [LEAF_ADDR-1:0]    res_leaf_addr,
    output logic [3:0]              res_num_rules,
    output logic [PACKET_WIDTH-1:0] res_packet,
    output logic [15:0]             drop_cnt1,
    output logic [15:0]             drop_cnt2,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_C = DEPTH[FIFO_AW:0];

    typedef struct packed {
        logic [SEQ_W-1:0]        seq;
        logic                    hit;
        logic [2:0]              level;
        logic [LEAF_ADDR-1:0]    addr;
        logic [3:0]              nrules;
        logic [PACKET_WIDTH-1:0] pkt;
    } entry_t;

    // One-hot rule field: highest set bit wins, empty field means zero rules.
    function automatic logic [3:0] nr_decode(input logic [7:0] oh);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) n = 4'(i + 1);
        end
        return n;
    endfunction

    function automatic entry_t mk_entry(
        input logic [SEQ_W-1:0]        seq,
        input logic                    matched,
        input logic [NODE_WIDTH-1:0]   node,
        input logic [PACKET_WIDTH-1:0] pkt
    );
        entry_t e;
        e.seq    = seq;
        e.hit    = matched;
        e.level  = node[3:1];
        e.addr   = matched ? node[LEAF_ADDR+11:12] : '0;
        e.nrules = matched ? nr_decode(node[11:4]) : 4'd0;
        e.pkt    = pkt;
        return e;
    endfunction

    logic             unused_ok;
    assign unused_ok = ^{node_in1[NODE_WIDTH-1:LEAF_ADDR+12], node_in1[0],
                         node_in2[NODE_WIDTH-1:LEAF_ADDR+12], node_in2[0]};

    entry_t           mem_q [2][DEPTH];
    logic [FIFO_AW-1:0] wp_q [2];
    logic [FIFO_AW-1:0] rp_q [2];
    logic [FIFO_AW:0] cnt_q [2];
    logic [FIFO_AW:0] cnt_d [2];
    logic [SEQ_W-1:0] seq_q [2];
    logic [15:0]      drop_q [2];

    entry_t           in_e [2];
    logic [1:0]       in_v;
    logic [1:0]       ne, full, push, pop, drop;

    entry_t           out_q, out_d;
    logic             valid_q, valid_d;
    logic             lane_q, lane_d;
    logic             rr_q, rr_d;
    logic             load, gnt;

    always_comb begin
        in_e[0] = mk_entry(seq_q[0], matched_in1, node_in1, packet_in1);
        in_e[1] = mk_entry(seq_q[1], matched_in2, node_in2, packet_in2);
        in_v    = {data_valid_in2, data_valid_in1};
        for (int l = 0; l < 2; l++) begin
            ne[l]   = cnt_q[l] != '0;
            full[l] = cnt_q[l] == FULL_C;
        end
    end

    // Output register refills whenever it is empty or being drained.
    always_comb begin
        load = (!valid_q || res_ready) && (ne != 2'b00);
        gnt  = rr_q;
        unique case (ne)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            default: gnt = rr_q;
        endcase
        pop = {load && gnt, load && !gnt};
    end

    // A full FIFO still accepts a push when it is popped the same cycle.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            push[l] = in_v[l] && (!full[l] || pop[l]);
            drop[l] = in_v[l] && full[l] && !pop[l];
            cnt_d[l] = cnt_q[l];
            unique case ({push[l], pop[l]})
                2'b10:   cnt_d[l] = cnt_q[l] + 1'b1;
                2'b01:   cnt_d[l] = cnt_q[l] - 1'b1;
                default: cnt_d[l] = cnt_q[l];
            endcase
        end
    end

    always_comb begin
        out_d   = out_q;
        lane_d  = lane_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        if (load) begin
            out_d   = mem_q[gnt][rp_q[gnt]];
            lane_d  = gnt;
            valid_d = 1'b1;
            if (ne == 2'b11) rr_d = ~gnt;
        end else if (res_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) mem_q[l][wp_q[l]] <= in_e[l];
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int l = 0; l < 2; l++) begin
                wp_q[l]   <= '0;
                rp_q[l]   <= '0;
                cnt_q[l]  <= '0;
                seq_q[l]  <= '0;
                drop_q[l] <= '0;
            end
            out_q   <= '0;
            lane_q  <= 1'b0;
            valid_q <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (push[l]) wp_q[l] <= wp_q[l] + 1'b1;
                if (pop[l])  rp_q[l] <= rp_q[l] + 1'b1;
                cnt_q[l] <= cnt_d[l];
                if (in_v[l]) seq_q[l] <= seq_q[l] + 1'b1;
                if (drop[l] && drop_q[l] != 16'hFFFF)
                    drop_q[l] <= drop_q[l] + 16'd1;
            end
            out_q   <= out_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    assign res_valid     = valid_q;
    assign res_lane      = lane_q;
    assign res_seq       = out_q.seq;
    assign res_hit       = out_q.hit;
    assign res_level     = out_q.level;
    assign res_leaf_addr = out_q.addr;
    assign res_num_rules = out_q.nrules;
    assign res_packet    = out_q.pkt;
    assign drop_cnt1     = drop_q[0];
    assign drop_cnt2     = drop_q[1];

`ifdef COLLECT_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (valid_q && res_ready) begin
            if (out_q.hit) hit_q  <= hit_q + 32'd1;
            else           miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_leaf_result_collector.sv
// Testbench for leaf_result_collector: directed and random traffic
// checked against a queue-based reference model.
module tb_leaf_result_collector;

    logic         clk = 1'b0;
    logic         RSTn;
    logic [103:0] p1, p2;
    logic         v1, v2, m1, m2;
    logic [39:0]  n1, n2;
    logic         rdy;
    logic         res_valid, res_lane, res_hit;
    logic [15:0]  res_seq, drop_cnt1, drop_cnt2;
    logic [2:0]   res_level;
    logic [11:0]  res_leaf_addr;
    logic [3:0]   res_num_rules;
    logic [103:0] res_packet;
    logic [31:0]  hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    leaf_result_collector dut (
        .clk(clk), .RSTn(RSTn),
        .packet_in1(p1), .packet_in2(p2),
        .data_valid_in1(v1), .data_valid_in2(v2),
        .node_in1(n1), .node_in2(n2),
        .matched_in1(m1), .matched_in2(m2),
        .res_valid(res_valid), .res_ready(rdy),
        .res_lane(res_lane), .res_seq(res_seq),
        .res_hit(res_hit), .res_level(res_level),
        .res_leaf_addr(res_leaf_addr),
        .res_num_rules(res_num_rules),
        .res_packet(res_packet),
        .drop_cnt1(drop_cnt1), .drop_cnt2(drop_cnt2),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct packed {
        logic [15:0]  seq;
        logic         hit;
        logic [2:0]   lvl;
        logic [11:0]  addr;
        logic [3:0]   nr;
        logic [103:0] pkt;
    } ent_t;

    ent_t        qa[$];
    ent_t        qb[$];
    ent_t        mout;
    logic        mv, mlane, mrr;
    logic [15:0] mseq [2];
    logic [15:0] mdrop [2];
    logic [31:0] mhit, mmiss;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [15:0] s, input logic m,
                                input logic [39:0] n,
                                input logic [103:0] p);
        ent_t e;
        int   cnt;
        cnt = 0;
        for (int i = 0; i < 8; i++)
            if (n[4+i]) cnt = i + 1;
        e.seq  = s;
        e.hit  = m;
        e.lvl  = n[3:1];
        e.addr = m ? n[23:12] : 12'd0;
        e.nr   = m ? 4'(cnt) : 4'd0;
        e.pkt  = p;
        return e;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        mout = '0;
        mv = 0; mlane = 0; mrr = 0;
        mseq[0] = 0; mseq[1] = 0;
        mdrop[0] = 0; mdrop[1] = 0;
        mhit = 0; mmiss = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        logic ln;
`ifdef COLLECT_STATS_EN
        if (mv && rdy) begin
            if (mout.hit) mhit++;
            else mmiss++;
        end
`endif
        if ((!mv || rdy) && (qa.size() > 0 || qb.size() > 0)) begin
            if (qa.size() > 0 && qb.size() > 0) begin
                ln = mrr;
                mrr = !mrr;
            end else begin
                ln = (qa.size() > 0) ? 1'b0 : 1'b1;
            end
            mout = ln ? qb.pop_front() : qa.pop_front();
            mlane = ln;
            mv = 1;
        end else if (rdy) begin
            mv = 0;
        end
        if (v1) begin
            e = mk(mseq[0], m1, n1, p1);
            mseq[0]++;
            if (qa.size() < 8) qa.push_back(e);
            else if (mdrop[0] != 16'hFFFF) mdrop[0]++;
        end
        if (v2) begin
            e = mk(mseq[1], m2, n2, p2);
            mseq[1]++;
            if (qb.size() < 8) qb.push_back(e);
            else if (mdrop[1] != 16'hFFFF) mdrop[1]++;
        end
    endtask

    task automatic check_all();
        chk("valid", res_valid, mv);
        if (mv) begin
            chk("lane", res_lane, mlane);
            chk("seq", res_seq, mout.seq);
            chk("hit", res_hit, mout.hit);
            chk("level", res_level, mout.lvl);
            chk("addr", res_leaf_addr, mout.addr);
            chk("nrules", res_num_rules, mout.nr);
            chk("packet", res_packet, mout.pkt);
        end
        chk("drop1", drop_cnt1, mdrop[0]);
        chk("drop2", drop_cnt2, mdrop[1]);
        chk("hit_cnt", hit_cnt, mhit);
        chk("miss_cnt", miss_cnt, mmiss);
    endtask

    task automatic step();
        @(posedge clk);
        if (RSTn) model_edge();
        #1;
        check_all();
    endtask

    function automatic logic [103:0] rpkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [39:0] node(input logic [11:0] a,
                                         input logic [7:0] nr,
                                         input logic [2:0] lv,
                                         input logic m);
        return {16'h0, a, nr, lv, m};
    endfunction

    task automatic lane1(input logic m, input logic [39:0] n);
        v1 = 1; m1 = m; n1 = n; p1 = rpkt();
    endtask

    task automatic lane2(input logic m, input logic [39:0] n);
        v2 = 1; m2 = m; n2 = n; p2 = rpkt();
    endtask

    function automatic logic [39:0] rnode(input logic m);
        logic [7:0] nr;
        nr = 8'($urandom);
        return node(12'($urandom), nr, 3'($urandom), m);
    endfunction

    task automatic idle(input int k);
        v1 = 0; v2 = 0;
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic do_reset();
        #2 RSTn = 0;
        #1;
        chk("rst_valid", res_valid, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        RSTn = 1;
        #1;
    endtask

    logic [159:0] held;
    logic         r;

    initial begin
        RSTn = 0; rdy = 0;
        v1 = 0; v2 = 0; m1 = 0; m2 = 0;
        n1 = '0; n2 = '0; p1 = '0; p2 = '0;
        model_reset();
        #1;
        chk("rst_valid0", res_valid, 1'b0);
        chk("rst_seq0", res_seq, 16'd0);
        chk("rst_packet0", res_packet, 104'd0);
        chk("rst_drop0", {drop_cnt1, drop_cnt2}, 32'd0);
        @(negedge clk);
        RSTn = 1;
        #1;

        // single hit lane1
        rdy = 1;
        lane1(1, node(12'h0A5, 8'b0000_0100, 3'd2, 1));
        step();
        chk("t1_notyet", res_valid, 1'b0);
        idle(1);
        chk("t1_valid", res_valid, 1'b1);
        chk("t1_lane", res_lane, 1'b0);
        chk("t1_seq", res_seq, 16'd0);
        chk("t1_hit", res_hit, 1'b1);
        chk("t1_addr", res_leaf_addr, 12'h0A5);
        chk("t1_nr", res_num_rules, 4'd3);
        chk("t1_lvl", res_level, 3'd2);
        idle(2);

        // both lanes, 4 cycles
        for (int i = 0; i < 4; i++) begin
            lane1(1, rnode(1));
            lane2(1, rnode(1));
            step();
        end
        idle(10);

        // lane2 stalled overflow, then drain
        rdy = 0;
        v1 = 0;
        for (int i = 0; i < 10; i++) begin
            lane2(1, rnode(1));
            step();
        end
        v2 = 0;
        step();
        held = {res_lane, res_seq, res_hit, res_level, res_leaf_addr,
                res_num_rules, res_packet};
        idle(3);
        chk("t3_hold", {res_lane, res_seq, res_hit, res_level,
                        res_leaf_addr, res_num_rules, res_packet}, held);
        chk("t3_drop_nz", drop_cnt2 != 16'd0, 1'b1);
        rdy = 1;
        idle(12);

        // miss with full rule field
        lane1(0, node(12'hFFF, 8'hFF, 3'd5, 0));
        step();
        idle(1);
        chk("t4_hit", res_hit, 1'b0);
        chk("t4_nr", res_num_rules, 4'd0);
        chk("t4_addr", res_leaf_addr, 12'd0);
        chk("t4_lvl", res_level, 3'd5);
        idle(2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            v1 = $urandom_range(0, 1);
            v2 = $urandom_range(0, 1);
            r = $urandom_range(0, 1);
            m1 = r; n1 = rnode(r); p1 = rpkt();
            r = $urandom_range(0, 1);
            m2 = r; n2 = rnode(r); p2 = rpkt();
            rdy = ($urandom_range(0, 9) < 7);
            step();
        end
        rdy = 1;
        idle(20);

        // reset with buffered entries
        rdy = 0;
        for (int i = 0; i < 5; i++) begin
            lane1(1, rnode(1));
            step();
        end
        v1 = 0;
        do_reset();
        chk("t5_drop", {drop_cnt1, drop_cnt2}, 32'd0);
        idle(3);
        rdy = 1;
        lane1(1, rnode(1));
        step();
        idle(1);
        chk("t5_seq", res_seq, 16'd0);
        idle(2);

        // statistics: 3 hits, 2 misses
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r = (i < 3);
            lane1(r, rnode(r));
            step();
        end
        idle(8);
`ifdef COLLECT_STATS_EN
        chk("t6_hits", hit_cnt, 32'd3);
        chk("t6_miss", miss_cnt, 32'd2);
`else
        chk("t6_hits", hit_cnt, 32'd0);
        chk("t6_miss", miss_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
